// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; WCNT clocks per bit, DEPTH FIFO entries.
// Define UART_TX_PARITY_EN to add an even-parity bit between D7 and the stop bit.
module uart_tx_fifo #(
    parameter int WCNT  = 100,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_txd,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [11:0]   RELOAD = 12'(WCNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_nx;
    logic [11:0] bit_cnt, bit_cnt_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        txd_nx;
    logic        pop, wr, has_data, bit_end;
    logic [AW-1:0] wptr, rptr;
    logic [7:0]  mem [DEPTH];
    logic [7:0]  head;

`ifdef UART_TX_PARITY_EN
    logic par_r;

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    assign has_data = (o_count != '0);
    assign o_ready  = (o_count != FULL);
    assign o_busy   = has_data || (state != IDLE);
    assign wr       = i_valid && o_ready;
    assign bit_end  = (bit_cnt == '0);
    assign head     = mem[rptr];

    always_comb begin
        state_nx   = state;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        txd_nx     = o_txd;
        pop        = 1'b0;
        bit_cnt_nx = bit_cnt;
        if (state != IDLE)
            bit_cnt_nx = bit_end ? RELOAD : bit_cnt - 12'd1;

        case (state)
            IDLE: begin
                if (has_data) begin
                    pop        = 1'b1;
                    shreg_nx   = head;
                    txd_nx     = 1'b0;
                    bit_cnt_nx = RELOAD;
                    state_nx   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_nx     = shreg[0];
                    bit_idx_nx = 3'd0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_nx   = par_r;
                        state_nx = PARITY;
`else
                        txd_nx   = 1'b1;
                        state_nx = STOP;
`endif
                    end else begin
                        txd_nx   = shreg[1];
                        shreg_nx = {1'b0, shreg[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    txd_nx   = 1'b1;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                // Back-to-back frames: the next start bit begins on the stop bit's final edge.
                if (bit_end) begin
                    if (has_data) begin
                        pop        = 1'b1;
                        shreg_nx   = head;
                        txd_nx     = 1'b0;
                        bit_cnt_nx = RELOAD;
                        state_nx   = START;
                    end else begin
                        txd_nx     = 1'b1;
                        bit_cnt_nx = 12'd0;
                        state_nx   = IDLE;
                    end
                end
            end
            default: begin
                txd_nx     = 1'b1;
                bit_cnt_nx = 12'd0;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_txd   <= 1'b1;
            bit_cnt <= 12'd0;
            bit_idx <= 3'd0;
            wptr    <= '0;
            rptr    <= '0;
            o_count <= '0;
        end else begin
            state   <= state_nx;
            o_txd   <= txd_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

    // Storage and shift register carry data only; pointers and count gate their meaning.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= i_data;
        shreg <= shreg_nx;
`ifdef UART_TX_PARITY_EN
        if (pop)
            par_r <= even_par(head);
`endif
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo with a queue-based line-level reference model.
module tb_uart_tx_fifo;

    localparam int WCNT  = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst, i_valid, o_ready, o_txd, o_busy;
    logic [7:0]    i_data;
    logic [CW-1:0] o_count;

    logic          rst2, valid2, ready2, txd2, busy2;
    logic [7:0]    data2;
    logic [4:0]    count2;

    uart_tx_fifo #(.WCNT(WCNT), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_txd(o_txd), .o_busy(o_busy), .o_count(o_count)
    );

    uart_tx_fifo #(.WCNT(100), .DEPTH(16)) u_dut100 (
        .clk(clk), .i_rst(rst2), .i_data(data2), .i_valid(valid2),
        .o_ready(ready2), .o_txd(txd2), .o_busy(busy2), .o_count(count2)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: queued bytes plus the frame currently on the line.
    logic [7:0]  q[$];
    logic        active = 1'b0;
    int          t = 0;
    logic [10:0] frame = '1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    task automatic model_edge();
        int  sz0;
        logic acc;
        if (i_rst) begin
            q.delete();
            active = 1'b0;
            t = 0;
            return;
        end
        sz0 = q.size();
        acc = i_valid && (sz0 != DEPTH);
        if (active) begin
            t++;
            if (t == FBITS * WCNT) active = 1'b0;
        end
        if (!active && sz0 != 0) begin
            frame  = make_frame(q.pop_front());
            active = 1'b1;
            t      = 0;
        end
        if (acc) q.push_back(i_data);
    endtask

    function automatic logic exp_txd();
        return active ? frame[t / WCNT] : 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("txd",   {31'd0, o_txd},   {31'd0, exp_txd()});
        check("busy",  {31'd0, o_busy},  {31'd0, (active || q.size() != 0)});
        check("count", 32'(o_count),     32'(q.size()));
        check("ready", {31'd0, o_ready}, {31'd0, (q.size() != DEPTH)});
    endtask

    task automatic push(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((o_busy !== 1'b0) && w < 2000) begin
            tick();
            w++;
        end
        check("drain_bound", {31'd0, (w < 2000)}, 32'd1);
    endtask

    logic [7:0] rx;
    logic       rx_stop;
    int         per;

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00;
        rst2  = 1'b1; valid2  = 1'b0; data2  = 8'h00;
        repeat (3) tick();
        i_rst = 1'b0; rst2 = 1'b0;
        check("rst_txd",   {31'd0, o_txd},  32'd1);
        check("rst_count", 32'(o_count),    32'd0);
        tick();

        // Single 0x55 frame with constant-derived timing points.
        push(8'h55);
        for (int k = 1; k <= WCNT * FBITS + 2; k++) begin
            tick();
            if (k == 1)  check("d55_start", {31'd0, o_txd}, 32'd0);
            if (k == 4)  check("d55_start_end", {31'd0, o_txd}, 32'd0);
            if (k == 5)  check("d55_d0", {31'd0, o_txd}, 32'd1);
            if (k == 9)  check("d55_d1", {31'd0, o_txd}, 32'd0);
            if (k == 33) check("d55_d7", {31'd0, o_txd}, 32'd0);
            if (k == WCNT * (FBITS - 1) + 1) check("d55_stop", {31'd0, o_txd}, 32'd1);
            if (k == WCNT * FBITS)           check("d55_busy_end", {31'd0, o_busy}, 32'd1);
            if (k == WCNT * FBITS + 1)       check("d55_idle", {31'd0, o_busy}, 32'd0);
        end

        // Back-to-back bytes: contiguous frames.
        push(8'h01); push(8'h02); push(8'h03);
        drain();

        // Six consecutive writes: one popped, four queued, one dropped.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        check("full_ready", {31'd0, o_ready}, 32'd0);
        push(8'h66);
        drain();

        // Reset during D3 of 0xA5 with two bytes queued.
        push(8'hA5); push(8'h5A); push(8'hC3);
        repeat (16) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("abort_txd",   {31'd0, o_txd},  32'd1);
        check("abort_count", 32'(o_count),    32'd0);
        check("abort_busy",  {31'd0, o_busy}, 32'd0);
        repeat (60) tick();

        // Randomized traffic with varying write density and rare resets.
        for (int ph = 0; ph < 6; ph++) begin
            per = (ph % 3 == 0) ? 2 : (ph % 3 == 1) ? 8 : 40;
            for (int c = 0; c < 600; c++) begin
                i_valid = ($urandom_range(per - 1) == 0);
                i_data  = 8'($urandom);
                i_rst   = ($urandom_range(1499) == 0);
                tick();
            end
            i_valid = 1'b0;
            i_rst   = 1'b0;
        end
        drain();

        // 0xC3 through the WCNT=100 instance, decoded by a mid-bit sampling receiver.
        valid2 = 1'b1; data2 = 8'hC3;
        tick();
        valid2 = 1'b0;
        begin
            int w = 0;
            while (txd2 !== 1'b0 && w < 20) begin
                tick();
                w++;
            end
            check("rx_start_seen", {31'd0, (w < 20)}, 32'd1);
        end
        repeat (50) tick();
        check("rx_start_mid", {31'd0, txd2}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (100) tick();
            rx[i] = txd2;
        end
        repeat (100 * (FBITS - 9)) tick();
        rx_stop = txd2;
        check("rx_data",  32'(rx), 32'hC3);
        check("rx_valid", {31'd0, rx_stop}, 32'd1);
        repeat (100) tick();
        check("rx_idle", {31'd0, busy2}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
